// File: rtl/mul_ctrl.sv
// ============================================================================
//  mul_ctrl : two-stage valid/ready wrapper around booth_multiplier (RV32 MUL/MULH/MULHU)
//  Optional feature macro: MUL_FLUSH_EN (adds the flush input)      Rev 1.0
// ============================================================================
`default_nettype none

module booth_multiplier (
    input  logic [33:0] x,
    input  logic [33:0] y,
    output logic [67:0] z
);
    logic [67:0] w_xe;
    logic [34:0] w_yp;
    logic [67:0] w_pp;
    logic [2:0]  w_grp;

    // Radix-4 Booth: 17 digit groups over the 34-bit signed multiplier
    always_comb begin
        w_xe  = {{34{x[33]}}, x};
        w_yp  = {y, 1'b0};
        w_pp  = '0;
        w_grp = '0;
        z     = '0;
        for (int i = 0; i < 17; i++) begin
            w_grp = w_yp[2*i +: 3];
            case (w_grp)
                3'b001, 3'b010: w_pp = w_xe;
                3'b011:         w_pp = w_xe << 1;
                3'b100:         w_pp = -(w_xe << 1);
                3'b101, 3'b110: w_pp = -w_xe;
                default:        w_pp = '0;
            endcase
            z = z + (w_pp << (2 * i));
        end
    end
endmodule

module mul_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        busy
`ifdef MUL_FLUSH_EN
    ,
    input  logic        flush
`endif
);
    localparam logic [1:0] OP_MULH_W  = 2'b01;
    localparam logic [1:0] OP_MULH_WU = 2'b10;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        S2    = 2'b01,
        S1    = 2'b10,
        FULL  = 2'b11
    } occ_t;

    occ_t        occ_q, occ_d;
    logic [33:0] x_q, x_d;
    logic [33:0] y_q, y_d;
    logic        op_hi_q, op_hi_d;
    logic [31:0] result_q, result_d;

    logic [1:0]  w_occ;
    logic        w_flush;
    logic        s1_valid, s2_valid, s1_d, s2_d;
    logic        s1_adv, w_accept, w_move, w_signed;
    logic [67:0] w_z;
    logic        w_unused_z;

`ifdef MUL_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_occ    = occ_q;
    assign s1_valid = w_occ[1];
    assign s2_valid = w_occ[0];
    assign s1_adv   = ~s2_valid | out_ready;
    assign in_ready = resetn & ~w_flush & (~s1_valid | s1_adv);
    assign w_accept = in_valid & in_ready;
    assign w_move   = s1_valid & s1_adv & ~w_flush;
    assign w_signed = (in_op != OP_MULH_WU);

    booth_multiplier u_booth (
        .x (x_q),
        .y (y_q),
        .z (w_z)
    );

    // Top four product bits are sign-extension guard bits and never selected
    assign w_unused_z = ^w_z[67:64];

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        op_hi_d  = op_hi_q;
        result_d = result_q;
        s1_d     = w_accept | (s1_valid & ~s1_adv);
        s2_d     = w_move | (s2_valid & ~out_ready);
        if (w_flush) begin
            s1_d = 1'b0;
            s2_d = 1'b0;
        end
        if (w_accept) begin
            x_d     = {{2{w_signed & in_src1[31]}}, in_src1};
            y_d     = {{2{w_signed & in_src2[31]}}, in_src2};
            op_hi_d = (in_op == OP_MULH_W) || (in_op == OP_MULH_WU);
        end
        if (w_move) begin
            result_d = op_hi_q ? w_z[63:32] : w_z[31:0];
        end
        occ_d = occ_t'({s1_d, s2_d});
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            occ_q    <= EMPTY;
            x_q      <= '0;
            y_q      <= '0;
            op_hi_q  <= 1'b0;
            result_q <= '0;
        end else begin
            occ_q    <= occ_d;
            x_q      <= x_d;
            y_q      <= y_d;
            op_hi_q  <= op_hi_d;
            result_q <= result_d;
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = result_q;
    assign busy       = s1_valid | s2_valid;

endmodule

`default_nettype wire

// File: tb/tb_mul_ctrl.sv
// ============================================================================
//  tb_mul_ctrl : directed self-checking bench for mul_ctrl (flush case under MUL_FLUSH_EN)
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_mul_ctrl;
    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        busy;
`ifdef MUL_FLUSH_EN
    logic        flush;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mul_ctrl u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
`ifdef MUL_FLUSH_EN
        ,
        .flush      (flush)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic offer(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
    endtask

    // One request with out_ready=1; idle inputs carry junk that must be ignored
    task automatic single(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        offer(1'b1, op, a, b);
        out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        offer(1'b0, 2'($urandom), $urandom, $urandom);
        chk({tag, "_valid_early"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_busy_s1"}, {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_result"}, out_result, exp);
        chk({tag, "_busy_s2"}, {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk({tag, "_valid_gone"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_busy_idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
`ifdef MUL_FLUSH_EN
        flush = 1'b0;
`endif
        resetn    = 1'b0;
        out_ready = 1'b1;
        offer(1'b1, 2'b00, 32'd5, 32'd5);
        #1 chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_result", out_result, 32'd0);
        resetn = 1'b1;
        offer(1'b0, 2'b00, 32'd0, 32'd0);

        single("mul_3x4",     2'b00, 32'd3,        32'd4,        32'h0000000C);
        single("mulh_m1",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        single("mulhu_m1",    2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        single("mulh_min",    2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
        single("mul_min_m1",  2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        single("mul_neg",     2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1);
        single("mulh_neg",    2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF);
        single("resv_7x9",    2'b11, 32'd7,        32'd9,        32'h0000003F);

        // Back-to-back A, B, C with a 4-cycle output stall
        @(negedge clk);
        out_ready = 1'b0;
        offer(1'b1, 2'b00, 32'd2, 32'd3);
        #1 chk("b2b_rdy_a", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        offer(1'b1, 2'b00, 32'd5, 32'd7);
        #1 chk("b2b_rdy_b", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        offer(1'b1, 2'b00, 32'd11, 32'd13);
        #1 chk("b2b_rdy_c_blocked", {31'b0, in_ready}, 32'd0);
        chk("b2b_valid_a", {31'b0, out_valid}, 32'd1);
        chk("b2b_res_a", out_result, 32'd6);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 chk("b2b_stall_rdy", {31'b0, in_ready}, 32'd0);
            chk("b2b_stall_hold", out_result, 32'd6);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 chk("b2b_rdy_c_open", {31'b0, in_ready}, 32'd1);
        chk("b2b_res_a_last", out_result, 32'd6);
        @(negedge clk);
        offer(1'b0, 2'b00, 32'd0, 32'd0);
        chk("b2b_valid_b", {31'b0, out_valid}, 32'd1);
        chk("b2b_res_b", out_result, 32'd35);
        chk("b2b_busy_full", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("b2b_valid_c", {31'b0, out_valid}, 32'd1);
        chk("b2b_res_c", out_result, 32'd143);
        @(negedge clk);
        chk("b2b_drained", {30'b0, busy, out_valid}, 32'd0);

        // Reset while FULL
        @(negedge clk);
        out_ready = 1'b0;
        offer(1'b1, 2'b00, 32'd100, 32'd3);
        @(negedge clk);
        offer(1'b1, 2'b00, 32'd9, 32'd9);
        @(negedge clk);
        chk("rfull_valid", {31'b0, out_valid}, 32'd1);
        chk("rfull_res", out_result, 32'h0000012C);
        resetn = 1'b0;
        offer(1'b1, 2'b00, 32'd4, 32'd4);
        #1 chk("rfull_rdy_in_rst", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        resetn    = 1'b1;
        out_ready = 1'b1;
        offer(1'b0, 2'b00, 32'd0, 32'd0);
        chk("rfull_valid_after", {31'b0, out_valid}, 32'd0);
        chk("rfull_busy_after", {31'b0, busy}, 32'd0);
        chk("rfull_res_after", out_result, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rfull_no_stale", {30'b0, busy, out_valid}, 32'd0);
        end
        single("post_rst", 2'b00, 32'd6, 32'd7, 32'd42);

`ifdef MUL_FLUSH_EN
        @(negedge clk);
        out_ready = 1'b0;
        offer(1'b1, 2'b00, 32'd10, 32'd3);
        @(negedge clk);
        offer(1'b1, 2'b00, 32'd9, 32'd9);
        @(negedge clk);
        chk("fl_full_busy", {31'b0, busy}, 32'd1);
        chk("fl_full_res", out_result, 32'h0000001E);
        flush = 1'b1;
        out_ready = 1'b1;
        offer(1'b1, 2'b00, 32'd8, 32'd8);
        #1 chk("fl_rdy", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        offer(1'b0, 2'b00, 32'd0, 32'd0);
        chk("fl_busy_after", {31'b0, busy}, 32'd0);
        chk("fl_valid_after", {31'b0, out_valid}, 32'd0);
        chk("fl_res_kept", out_result, 32'h0000001E);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("fl_not_accepted", {30'b0, busy, out_valid}, 32'd0);
        end
        single("post_flush", 2'b00, 32'd2, 32'd2, 32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
